// File: rtl/rfaludm_controller_if.sv
// rfaludm_controller_if: fetch handshake and datapath control bundle for the LEGv8 controller
interface rfaludm_controller_if;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic        Zero;
    logic [1:0]  ALUOp;
    logic [10:0] OpCodefield;
    logic [4:0]  Read1;
    logic [4:0]  Read2;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  DispIn;
    logic        ALUSrc_Select;
    logic        MemtoReg_Select;
    logic        Done;
    logic        BranchTaken;
    logic        IllegalOp;
    modport master (
        output Instr, InstrValid, Zero,
        input  InstrReady, ALUOp, OpCodefield, Read1, Read2, WriteReg, RegWrite, MemRead,
               MemWrite, DispIn, ALUSrc_Select, MemtoReg_Select, Done, BranchTaken, IllegalOp
    );
    modport slave (
        input  Instr, InstrValid, Zero,
        output InstrReady, ALUOp, OpCodefield, Read1, Read2, WriteReg, RegWrite, MemRead,
               MemWrite, DispIn, ALUSrc_Select, MemtoReg_Select, Done, BranchTaken, IllegalOp
    );
endinterface

// File: rtl/rfaludm_controller.sv
// rfaludm_controller: multi-cycle LEGv8 controller (R-type, LDUR, STUR, CBZ) driving a regfile/ALU/data-memory datapath
module rfaludm_controller (
    input  logic                  clock,
    input  logic                  reset,
    rfaludm_controller_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {K_ILL, K_R, K_LD, K_ST, K_CB} kind_t;
    state_t      r_state, w_next;
    kind_t       r_kind, w_kind;
    logic [1:0]  r_aluop;
    logic [10:0] r_opc, w_op;
    logic [4:0]  r_rd1, r_rd2, r_wr;
    logic [8:0]  r_disp;
    logic        r_alusrc, r_m2r;
    logic        w_accept, w_final, w_unused;
    assign w_unused = ^bus.Instr[11:10];
    assign w_op = bus.Instr[31:21];
    assign w_kind = (w_op == 11'b10001011000 || w_op == 11'b11001011000 ||
                     w_op == 11'b10001010000 || w_op == 11'b10101010000) ? K_R :
                    (w_op == 11'b11111000010) ? K_LD :
                    (w_op == 11'b11111000000) ? K_ST :
                    (bus.Instr[31:24] == 8'b10110100) ? K_CB : K_ILL;
    assign bus.InstrReady = (r_state == IDLE) && !reset;
    assign w_accept = bus.InstrReady && bus.InstrValid;
    assign w_final = (r_state == DECODE && r_kind == K_ILL) || (r_state == EXEC && r_kind == K_CB) ||
                     (r_state == MEM && r_kind == K_ST) || (r_state == WB);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? DECODE : IDLE;
            DECODE:  w_next = (r_kind == K_ILL) ? IDLE : EXEC;
            EXEC:    w_next = (r_kind == K_R) ? WB : (r_kind == K_LD || r_kind == K_ST) ? MEM : IDLE;
            MEM:     w_next = (r_kind == K_LD) ? WB : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        r_state <= reset ? IDLE : w_next;
        if (reset || w_final) begin
            r_kind   <= K_ILL;
            r_aluop  <= '0;
            r_opc    <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_wr     <= '0;
            r_disp   <= '0;
            r_alusrc <= 1'b0;
            r_m2r    <= 1'b0;
        end else if (w_accept) begin
            r_kind   <= w_kind;
            r_aluop  <= (w_kind == K_R) ? 2'b10 : (w_kind == K_CB) ? 2'b01 : 2'b00;
            r_opc    <= w_op;
            r_rd1    <= (w_kind == K_R || w_kind == K_LD || w_kind == K_ST) ? bus.Instr[9:5] : 5'd0;
            r_rd2    <= (w_kind == K_R) ? bus.Instr[20:16] :
                        (w_kind == K_ST || w_kind == K_CB) ? bus.Instr[4:0] : 5'd0;
            r_wr     <= (w_kind == K_R || w_kind == K_LD) ? bus.Instr[4:0] : 5'd0;
            r_disp   <= bus.Instr[20:12];
            r_alusrc <= (w_kind == K_LD || w_kind == K_ST);
            r_m2r    <= (w_kind == K_LD);
        end
    end
    assign bus.ALUOp           = r_aluop;
    assign bus.OpCodefield     = r_opc;
    assign bus.Read1           = r_rd1;
    assign bus.Read2           = r_rd2;
    assign bus.WriteReg        = r_wr;
    assign bus.DispIn          = r_disp;
    assign bus.ALUSrc_Select   = r_alusrc;
    assign bus.MemtoReg_Select = r_m2r;
    assign bus.RegWrite        = (r_state == WB) && (r_wr != 5'd31);
    assign bus.MemRead         = (r_state == MEM || r_state == WB) && (r_kind == K_LD);
    assign bus.MemWrite        = (r_state == MEM) && (r_kind == K_ST);
    assign bus.Done            = w_final;
    assign bus.BranchTaken     = (r_state == EXEC) && (r_kind == K_CB) && bus.Zero;
    assign bus.IllegalOp       = (r_state == DECODE) && (r_kind == K_ILL);
endmodule

// File: doc/rfaludm_controller.md
RFALUDM_CONTROLLER -- requirements
Module: rfaludm_controller

Interface
REQ-001 Port: clock, input, 1, single system clock; all state updates on rising edge.
REQ-002 Port: reset, input, 1, synchronous active-high reset, sampled on rising edge of clock.
REQ-003 Port: Instr, input, 32, LEGv8 instruction word offered by the fetch side.
REQ-004 Port: InstrValid, input, 1, Instr is valid this cycle.
REQ-005 Port: InstrReady, output, 1, controller can accept an instruction this cycle.
REQ-006 Port: Zero, input, 1, ALU zero flag from the register-file/ALU/data-memory datapath.
REQ-007 Port: ALUOp, output, 2, ALU op class: 00 add for LDUR/STUR, 01 pass-B for CBZ, 10 R-type.
REQ-008 Port: OpCodefield, output, 11, Instr[31:21] of the latched instruction.
REQ-009 Port: Read1 / Read2 / WriteReg, output, 5 each, register-file addresses.
REQ-010 Port: RegWrite / MemRead / MemWrite, output, 1 each, datapath write and read strobes.
REQ-011 Port: DispIn, output, 9, D-type displacement Instr[20:12].
REQ-012 Port: ALUSrc_Select, output, 1; 1 selects DispIn as ALU B, 0 selects Read2 data.
REQ-013 Port: MemtoReg_Select, output, 1; 1 writes memory data to the register file, 0 writes ALU result.
REQ-014 Port: Done, output, 1, one-cycle pulse in the final cycle of each instruction.
REQ-015 Port: BranchTaken / IllegalOp, output, 1 each, qualified by Done.

Function
REQ-016 The FSM SHALL have the states IDLE, DECODE, EXEC, MEM and WB.
REQ-017 InstrReady SHALL be 1 only in IDLE with reset low; the instruction SHALL be latched on the edge where InstrValid and InstrReady are both 1, and the next state SHALL be DECODE.
REQ-018 Decode SHALL recognise: R-type ADD 10001011000, SUB 11001011000, AND 10001010000 and ORR 10101010000; LDUR 11111000010; STUR 11111000000; CBZ Instr[31:24]=10110100. Every other encoding is illegal.
REQ-019 Field mapping SHALL be: R-type Read1=Rn[9:5], Read2=Rm[20:16], WriteReg=Rd[4:0]; LDUR Read1=Rn, WriteReg=Rt[4:0], Read2=0; STUR Read1=Rn, Read2=Rt, WriteReg=0; CBZ Read1=0, Read2=Rt, WriteReg=0.
REQ-020 Control outputs SHALL be registered, valid from DECODE onward, held constant until the instruction's final cycle, and SHALL return to 0 in IDLE.
REQ-021 Paths SHALL be: R-type DECODE->EXEC->WB->IDLE; LDUR DECODE->EXEC->MEM->WB->IDLE; STUR DECODE->EXEC->MEM->IDLE; CBZ DECODE->EXEC->IDLE; illegal DECODE->IDLE.
REQ-022 RegWrite SHALL be 1 only in WB and SHALL be suppressed when WriteReg=31 (XZR).
REQ-023 MemRead SHALL be 1 in MEM and WB for LDUR; MemWrite SHALL be 1 only in MEM for STUR, for exactly one cycle.
REQ-024 ALUSrc_Select SHALL be 1 for LDUR/STUR and 0 otherwise; MemtoReg_Select SHALL be 1 only for LDUR.
REQ-025 Done SHALL pulse in WB (R-type, LDUR), in MEM (STUR), in EXEC (CBZ) and in DECODE (illegal).
REQ-026 BranchTaken SHALL equal Zero sampled in EXEC of CBZ, asserted with Done; it SHALL be 0 for all other instructions.
REQ-027 IllegalOp SHALL pulse with Done for illegal encodings; no RegWrite, MemRead or MemWrite SHALL be asserted for them.
REQ-028 InstrValid while not InstrReady SHALL be ignored; the next instruction SHALL be accepted in the cycle after Done, so there is no back-to-back overlap.

Reset
REQ-029 With reset high at an edge, the state SHALL become IDLE and all outputs SHALL be 0, InstrReady included, in the following cycle.
REQ-030 Reset mid-instruction SHALL abort the instruction: no later RegWrite or MemWrite and no Done; InstrReady SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-031 Instr=0x8B020023 (ADD X3,X1,X2), accepted -> DECODE: Read1=1, Read2=2, WriteReg=3, ALUOp=10, OpCodefield=10001011000; WB: RegWrite=1, Done=1, 3 cycles after accept.
REQ-032 Instr=0xF8428005 (LDUR X5,[X0,#40]) -> DispIn=000101000, ALUSrc_Select=1, MemRead=1 in MEM and WB, MemtoReg_Select=1, RegWrite=1 only in WB, Done in cycle 4.
REQ-033 Instr=0xF805000A (STUR X10,[X0,#80]) -> Read2=10, DispIn=001010000, MemWrite=1 for exactly one cycle, RegWrite never 1, Done in cycle 3.
REQ-034 Instr=0xB4000007 (CBZ X7), with Zero=1 and then Zero=0 on a repeat -> ALUOp=01, Read2=7; Done in cycle 2 with BranchTaken=1, then 0 on the repeat.
REQ-035 Instr=0x00000000 -> IllegalOp=1 and Done=1 in DECODE, no strobes; an ADD with Rd=31 -> RegWrite stays 0.
REQ-036 Reset pulsed during MEM of STUR -> MemWrite is 0 from the next cycle, no Done, InstrReady=1 after reset deasserts; InstrValid held high during EXEC -> no second accept.
